// File: rtl/tamagotchi_pkg.sv
// Shared pet-state codes, per-state animation lengths and frame geometry.
// MORTO_HOLD_EN: when defined, the MORTO animation stops on its last frame instead of looping.
package tamagotchi_pkg;

    localparam int unsigned FRAME_BYTES = 1024;
    localparam int unsigned ADDR_W      = 10;

    typedef enum logic [3:0] {
        EST_IDLE       = 4'b0000,
        EST_DORMINDO   = 4'b0001,
        EST_COMENDO    = 4'b0010,
        EST_DANDO_AULA = 4'b0100,
        EST_MORTO      = 4'b1000
    } estado_e;

    typedef enum logic [1:0] {
        S_START,
        S_FETCH,
        S_SEND,
        S_GAP
    } fase_e;

    function automatic logic [3:0] n_quadros(input logic [3:0] e);
        case (e)
            EST_DORMINDO:   return 4'd4;
            EST_COMENDO:    return 4'd5;
            EST_DANDO_AULA: return 4'd7;
            EST_MORTO:      return 4'd8;
            default:        return 4'd6;
        endcase
    endfunction

    // Multi-hot codes are invalid requests and fall back to IDLE.
    function automatic logic [3:0] sanitiza(input logic [3:0] e);
        return $onehot0(e) ? e : EST_IDLE;
    endfunction

    function automatic logic [2:0] proximo_quadro(input logic [3:0] e, input logic [2:0] i);
`ifdef MORTO_HOLD_EN
        if (e == EST_MORTO && i == 3'd7) return i;
`endif
        if ({1'b0, i} >= n_quadros(e) - 4'd1) return '0;
        return i + 3'd1;
    endfunction

endpackage

// File: rtl/sequenciador_quadros_if.sv
// Byte stream from the frame sequencer towards the display transmitter.
interface sequenciador_quadros_if;
    import tamagotchi_pkg::*;

    logic              tx_ready;
    logic              tx_valid;
    logic [ADDR_W-1:0] byte_counter;

    modport master (output tx_valid, output byte_counter, input tx_ready);
    modport slave  (input tx_valid, input byte_counter, output tx_ready);
endinterface

// File: rtl/divisor_animacao.sv
// Free-running animation tick: one-cycle pulse every ANIM_DIV clock cycles.
module divisor_animacao #(
    parameter int unsigned ANIM_DIV = 16777216
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int unsigned W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == W'(ANIM_DIV - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/sequenciador_quadros.sv
// OLED frame sequencer: walks the image controller through one frame per animation tick.
module sequenciador_quadros
    import tamagotchi_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = tamagotchi_pkg::FRAME_BYTES,
    parameter int unsigned ANIM_DIV    = 16777216
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             estado,
    sequenciador_quadros_if.master disp,
    output logic [3:0]             estado_quadro,
    output logic [2:0]             frame_index,
    output logic                   frame_start,
    output logic                   frame_done
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_BYTES - 1);

    fase_e             fase_q, fase_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [3:0]        eq_q, eq_d;
    logic [2:0]        idx_q, idx_d;
    logic              pend_q, pend_d;
    logic              fstart_q, fstart_d;
    logic              tick;
    logic [3:0]        est_san;

    divisor_animacao #(.ANIM_DIV(ANIM_DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign est_san           = sanitiza(estado);
    assign disp.tx_valid     = (fase_q == S_SEND);
    assign disp.byte_counter = cnt_q;
    assign frame_done        = (fase_q == S_SEND) && disp.tx_ready && (cnt_q == LAST);
    assign frame_start       = fstart_q;
    assign estado_quadro     = eq_q;
    assign frame_index       = idx_q;

    always_comb begin
        fase_d   = fase_q;
        cnt_d    = cnt_q;
        eq_d     = eq_q;
        idx_d    = idx_q;
        pend_d   = pend_q | tick;
        fstart_d = 1'b0;
        unique case (fase_q)
            S_START: begin
                eq_d     = est_san;
                cnt_d    = '0;
                fstart_d = 1'b1;
                fase_d   = S_FETCH;
                // Clear the old request but keep a tick landing right now for the next frame.
                pend_d   = tick;
                if (est_san != eq_q) idx_d = '0;
                else if (pend_q)     idx_d = proximo_quadro(eq_q, idx_q);
            end
            S_FETCH: fase_d = S_SEND;
            S_SEND: begin
                if (disp.tx_ready) begin
                    if (cnt_q == LAST) begin
                        fase_d = S_GAP;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        fase_d = S_FETCH;
                    end
                end
            end
            S_GAP:   if (pend_q || tick) fase_d = S_START;
            default: fase_d = S_START;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fase_q   <= S_START;
            cnt_q    <= '0;
            eq_q     <= '0;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            fase_q   <= fase_d;
            cnt_q    <= cnt_d;
            eq_q     <= eq_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            fstart_q <= fstart_d;
        end
    end
endmodule

// File: tb/tb_sequenciador_quadros.sv
// Scoreboard bench for sequenciador_quadros: event-timing reference model feeding a queue, separate monitor.
`timescale 1ns/1ps
module tb_sequenciador_quadros;
    localparam int unsigned NB  = 1024;
    localparam int unsigned DIV = 4000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] estado = 4'b0100;
    logic [3:0] estado_quadro;
    logic [2:0] frame_index;
    logic       frame_start;
    logic       frame_done;
    bit         rand_rdy = 1'b0;

    sequenciador_quadros_if disp_if ();

    sequenciador_quadros #(.FRAME_BYTES(NB), .ANIM_DIV(DIV)) dut (
        .clk           (clk),
        .rst           (rst),
        .estado        (estado),
        .disp          (disp_if.master),
        .estado_quadro (estado_quadro),
        .frame_index   (frame_index),
        .frame_start   (frame_start),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        disp_if.tx_ready = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
    end

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    // Reference rules stated directly: code cleanup, animation length, next frame number.
    function automatic logic [3:0] ref_code(input logic [3:0] e);
        return ($countones(e) > 1) ? 4'b0000 : e;
    endfunction

    function automatic int unsigned ref_size(input logic [3:0] c);
        case (c)
            4'b0001: return 4;
            4'b0010: return 5;
            4'b0100: return 7;
            4'b1000: return 8;
            default: return 6;
        endcase
    endfunction

    function automatic int unsigned ref_next(input logic [3:0] c, input int unsigned i);
`ifdef MORTO_HOLD_EN
        if (c == 4'b1000) return (i >= 7) ? 7 : i + 1;
`endif
        return (i + 1) % ref_size(c);
    endfunction

    typedef struct {
        bit          is_start;
        int unsigned cyc;
        int unsigned addr;
        bit          done;
        logic [3:0]  eq;
        int unsigned idx;
    } ev_t;

    ev_t expq[$];

    // Reference model: predicts when each frame starts and when each byte is accepted.
    int unsigned m_cyc, m_addr, m_offer, m_idx, m_next_start;
    bit          m_start_known, m_in_frame, m_tick_since, m_tk;
    logic [3:0]  m_eq, m_code;
    ev_t         m_ev;

    always @(negedge clk) begin
        if (rst) begin
            m_cyc = 0; m_next_start = 0; m_start_known = 1'b1; m_in_frame = 1'b0;
            m_tick_since = 1'b0; m_eq = 4'b0000; m_idx = 0; m_addr = 0; m_offer = 0;
            expq.delete();
        end else begin
            m_tk = ((m_cyc % DIV) == DIV - 1);
            if (m_start_known && m_next_start == m_cyc) begin
                m_code = ref_code(estado);
                if (m_code != m_eq)     m_idx = 0;
                else if (m_tick_since)  m_idx = ref_next(m_code, m_idx);
                m_eq = m_code;
                m_ev = '{is_start: 1'b1, cyc: m_cyc + 1, addr: 0, done: 1'b0, eq: m_eq, idx: m_idx};
                expq.push_back(m_ev);
                m_in_frame = 1'b1; m_addr = 0; m_offer = m_cyc + 2;
                m_tick_since = m_tk; m_start_known = 1'b0;
            end else begin
                m_tick_since = m_tick_since | m_tk;
                if (m_in_frame && m_cyc >= m_offer && disp_if.tx_ready === 1'b1) begin
                    m_ev = '{is_start: 1'b0, cyc: m_cyc, addr: m_addr, done: (m_addr == NB - 1),
                             eq: m_eq, idx: m_idx};
                    expq.push_back(m_ev);
                    if (m_addr == NB - 1) begin
                        m_in_frame = 1'b0;
                        if (m_tick_since) begin m_next_start = m_cyc + 2; m_start_known = 1'b1; end
                    end else begin
                        m_addr++; m_offer = m_cyc + 2;
                    end
                end else if (!m_in_frame && !m_start_known && m_tk) begin
                    m_next_start = m_cyc + 1; m_start_known = 1'b1;
                end
            end
            m_cyc++;
        end
    end

    // Monitor: pops the expected event whenever the DUT presents a frame start or a handshake.
    int unsigned mon_cyc, fs_cnt = 0, fd_cnt = 0;
    bit          prev_stall;
    logic [9:0]  prev_addr;
    logic [6:0]  flog[$];
    ev_t         ev;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            mon_cyc = 0; prev_stall = 1'b0;
            chk(disp_if.tx_valid === 1'b0, "rst_tx_valid", disp_if.tx_valid, 0);
            chk(disp_if.byte_counter === 10'd0, "rst_byte_counter", disp_if.byte_counter, 0);
            chk(frame_index === 3'd0, "rst_frame_index", frame_index, 0);
            chk(estado_quadro === 4'd0, "rst_estado_quadro", estado_quadro, 0);
            chk(frame_start === 1'b0, "rst_frame_start", frame_start, 0);
            chk(frame_done === 1'b0, "rst_frame_done", frame_done, 0);
        end else begin
            while (expq.size() != 0 && expq[0].cyc < mon_cyc) begin
                chk(1'b0, "missed_event_cycle", mon_cyc, expq[0].cyc);
                void'(expq.pop_front());
            end
            if (prev_stall) begin
                chk(disp_if.tx_valid === 1'b1, "stall_tx_valid", disp_if.tx_valid, 1);
                chk(disp_if.byte_counter === prev_addr, "stall_byte_counter", disp_if.byte_counter, prev_addr);
            end
            prev_stall = (disp_if.tx_valid === 1'b1) && (disp_if.tx_ready === 1'b0);
            prev_addr  = disp_if.byte_counter;
            if (frame_start === 1'b1) begin
                fs_cnt++;
                flog.push_back({estado_quadro, frame_index});
                if (expq.size() == 0 || !expq[0].is_start) begin
                    chk(1'b0, "unexpected_frame_start_cycle", mon_cyc, 0);
                end else begin
                    ev = expq.pop_front();
                    chk(ev.cyc == mon_cyc, "frame_start_cycle", mon_cyc, ev.cyc);
                    chk(estado_quadro === ev.eq, "estado_quadro", estado_quadro, ev.eq);
                    chk(frame_index === 3'(ev.idx), "frame_index", frame_index, ev.idx);
                end
            end
            if (disp_if.tx_valid === 1'b1 && disp_if.tx_ready === 1'b1) begin
                if (frame_done === 1'b1) fd_cnt++;
                if (expq.size() == 0 || expq[0].is_start) begin
                    chk(1'b0, "unexpected_handshake_addr", disp_if.byte_counter, 0);
                end else begin
                    ev = expq.pop_front();
                    chk(ev.cyc == mon_cyc, "handshake_cycle", mon_cyc, ev.cyc);
                    chk(disp_if.byte_counter === 10'(ev.addr), "handshake_addr", disp_if.byte_counter, ev.addr);
                    chk(frame_done === ev.done, "frame_done", frame_done, ev.done);
                end
            end else if (frame_done !== 1'b0) begin
                chk(1'b0, "frame_done_without_handshake", frame_done, 0);
            end
            mon_cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_starts(input int unsigned n);
        int unsigned target;
        int unsigned budget;
        target = fs_cnt + n;
        budget = n * 6000;
        do begin step(); budget--; end while (fs_cnt < target && budget != 0);
        if (fs_cnt < target) chk(1'b0, "timeout_frame_start_count", fs_cnt, target);
    endtask

    task automatic wait_byte(input logic [9:0] a);
        int unsigned budget;
        budget = 6000;
        do begin step(); budget--; end
        while (!(disp_if.tx_valid === 1'b1 && disp_if.byte_counter === a) && budget != 0);
        if (!(disp_if.tx_valid === 1'b1 && disp_if.byte_counter === a))
            chk(1'b0, "timeout_byte_counter", disp_if.byte_counter, a);
    endtask

    task automatic wait_done();
        int unsigned target;
        int unsigned budget;
        target = fd_cnt + 1;
        budget = 6000;
        do begin step(); budget--; end while (fd_cnt < target && budget != 0);
        if (fd_cnt < target) chk(1'b0, "timeout_frame_done_count", fd_cnt, target);
    endtask

    task automatic chk_log(input int unsigned i, input logic [3:0] eq, input int unsigned idx, input string name);
        if (i < flog.size()) chk(flog[i] == {eq, 3'(idx)}, name, flog[i], {eq, 3'(idx)});
        else                 chk(1'b0, name, flog.size(), i + 1);
    endtask

    int unsigned seq_b[10] = '{0, 1, 2, 3, 4, 5, 6, 0, 1, 2};

    initial begin
        #1 rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Abort the first frame at byte 300, then request an invalid multi-hot code.
        wait_byte(10'd300);
        rst = 1'b1;
        estado = 4'b0110;
        repeat (2) step();
        rst = 1'b0;
        flog.delete();
        wait_starts(1);
        chk_log(0, 4'b0000, 0, "invalid_code_as_idle");

        // DANDO_AULA for ten frames with a randomly stalling transmitter.
        estado = 4'b0100;
        flog.delete();
        rand_rdy = 1'b1;
        wait_starts(10);
        rand_rdy = 1'b0;
        for (int i = 0; i < 10; i++) chk_log(i, 4'b0100, seq_b[i], "dando_aula_sequence");

        // DORMINDO, switched to COMENDO mid-frame.
        estado = 4'b0001;
        flog.delete();
        wait_starts(1);
        chk_log(0, 4'b0001, 0, "dormindo_first");
        wait_byte(10'd500);
        estado = 4'b0010;
        repeat (4) step();
        chk(estado_quadro === 4'b0001, "estado_quadro_held_midframe", estado_quadro, 1);
        chk(frame_index === 3'd0, "frame_index_held_midframe", frame_index, 0);
        wait_starts(1);
        chk_log(1, 4'b0010, 0, "comendo_first");

        // MORTO for nine frames: reaches 7, then holds or wraps.
        estado = 4'b1000;
        flog.delete();
        wait_starts(9);
        chk_log(0, 4'b1000, 0, "morto_first");
        chk_log(7, 4'b1000, 7, "morto_last_frame");
`ifdef MORTO_HOLD_EN
        chk_log(8, 4'b1000, 7, "morto_after_last");
`else
        chk_log(8, 4'b1000, 0, "morto_after_last");
`endif
        wait_done();
        repeat (3) step();
        chk(expq.size() == 0, "unconsumed_expected_events", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #(10 * 110000);
        chk(1'b0, "global_timeout_cycles", 110000, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
